// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sampler and its settle timer.
package tt_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } tt_state_e;

    localparam int DEFAULT_SETTLE_CYCLES = 1;

    // Number of input vectors swept for an n-input primitive.
    function automatic int num_vec(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Counts 0..SETTLE_CYCLES-1 while enabled and flags the last cycle of each hold window.
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic window_end
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    assign window_end = enable && (cnt_q == CW'(SETTLE_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= window_end ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/truth_table_sampler.sv
// Sweeps every input vector into a combinational DUT, rebuilds its minterm mask
// and compares it against an expected mask latched at start.
module truth_table_sampler
    import tt_pkg::*;
#(
    parameter int NUM_IN        = 3,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        f_in,
    input  logic [num_vec(NUM_IN)-1:0]  expected_mask,
    output logic [NUM_IN-1:0]           abc_out,
    output logic                        busy,
    output logic                        done,
    output logic [num_vec(NUM_IN)-1:0]  minterm_mask,
    output logic                        match
);

    localparam int NV = num_vec(NUM_IN);

    tt_state_e          state_q, state_d;
    logic [NUM_IN-1:0]  idx_q, idx_d;
    logic [NV-1:0]      work_q, work_d;
    logic [NV-1:0]      exp_q, exp_d;
    logic [NV-1:0]      mask_q, mask_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               match_q, match_d;
    logic               timer_load;
    logic               window_end;

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .enable     (state_q == SWEEP),
        .window_end (window_end)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        work_d     = work_q;
        exp_d      = exp_q;
        mask_d     = mask_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        match_d    = match_q;
        timer_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SWEEP;
                    busy_d     = 1'b1;
                    idx_d      = '0;
                    work_d     = '0;
                    exp_d      = expected_mask;
                    timer_load = 1'b1;
                end
            end
            SWEEP: begin
                if (window_end) begin
                    work_d[idx_q] = f_in;
                    if (idx_q == {NUM_IN{1'b1}}) begin
                        // Last vector: publish the mask including the bit just captured.
                        state_d = IDLE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        mask_d  = work_d;
                        match_d = (work_d == exp_q);
                    end else begin
                        idx_d = idx_q + NUM_IN'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            work_q  <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign abc_out      = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign minterm_mask = mask_q;
    assign match        = match_q;

endmodule

// File: tb/tb_truth_table_sampler.sv
// Self-checking bench: random and directed truth tables driven through the sampler.
module tb_truth_table_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [7:0] tab0, tab1, exp0, exp1;
    logic       f0, f1;
    logic [2:0] abc0, abc1;
    logic       busy0, busy1, done0, done1, match0, match1;
    logic [7:0] mask0, mask1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Combinational DUTs under characterisation: f = tab[abc].
    assign f0 = tab0[abc0];
    assign f1 = tab1[abc1];

    truth_table_sampler #(.NUM_IN(3), .SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .f_in(f0), .expected_mask(exp0),
        .abc_out(abc0), .busy(busy0), .done(done0), .minterm_mask(mask0), .match(match0)
    );

    truth_table_sampler #(.NUM_IN(3), .SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1), .expected_mask(exp1),
        .abc_out(abc1), .busy(busy1), .done(done1), .minterm_mask(mask1), .match(match1)
    );

    task automatic test_reset();
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        tab0 = 8'h00; tab1 = 8'h00; exp0 = 8'h00; exp1 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({abc0, busy0, done0, mask0, match0} !== 13'd0) begin
            bad++; $display("FAIL reset0: got %b want 0", {abc0, busy0, done0, mask0, match0});
        end
        total++;
        if ({abc1, busy1, done1, mask1, match1} !== 13'd0) begin
            bad++; $display("FAIL reset1: got %b want 0", {abc1, busy1, done1, mask1, match1});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    // One full sweep on dut0; the reference is simply the table itself.
    task automatic run_sweep0(input logic [7:0] tab, input logic [7:0] exp, input string name);
        logic [7:0] prev;
        int k;
        tab0 = tab; exp0 = exp; prev = mask0;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        exp0 = ~exp;  // must have been latched at start
        k = 0;
        while (done0 !== 1'b1 && k < 40) begin
            total++;
            if (busy0 !== 1'b1 || abc0 !== k[2:0]) begin
                bad++; $display("FAIL %s step%0d: busy=%b abc=%0d want busy=1 abc=%0d", name, k, busy0, abc0, k[2:0]);
            end
            total++;
            if (mask0 !== prev) begin
                bad++; $display("FAIL %s hold_mask: got %h want %h", name, mask0, prev);
            end
            @(posedge clk); #1; k++;
        end
        total++;
        if (k != 8) begin bad++; $display("FAIL %s latency: got %0d want 8", name, k); end
        total++;
        if (mask0 !== tab) begin bad++; $display("FAIL %s mask: got %h want %h", name, mask0, tab); end
        total++;
        if (match0 !== (tab == exp)) begin
            bad++; $display("FAIL %s match: got %b want %b", name, match0, tab == exp);
        end
        total++;
        if (busy0 !== 1'b0 || abc0 !== 3'd0) begin
            bad++; $display("FAIL %s end_state: busy=%b abc=%0d want 0 0", name, busy0, abc0);
        end
        @(posedge clk); #1;
        total++;
        if (done0 !== 1'b0) begin bad++; $display("FAIL %s done_width: got %b want 0", name, done0); end
    endtask

    task automatic test_udp();
        run_sweep0(8'hE3, 8'hE3, "udp_match");
    endtask

    task automatic test_mismatch();
        run_sweep0(8'hE3, 8'hD5, "udp_mismatch");
    endtask

    task automatic test_settle3();
        int k;
        tab1 = 8'h80; exp1 = 8'h80;
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        k = 0;
        while (done1 !== 1'b1 && k < 60) begin
            total++;
            if (busy1 !== 1'b1 || abc1 !== 3'(k / 3)) begin
                bad++; $display("FAIL settle3 step%0d: busy=%b abc=%0d want 1 %0d", k, busy1, abc1, k / 3);
            end
            @(posedge clk); #1; k++;
        end
        total++;
        if (k != 24) begin bad++; $display("FAIL settle3 latency: got %0d want 24", k); end
        total++;
        if (mask1 !== 8'h80 || match1 !== 1'b1) begin
            bad++; $display("FAIL settle3 result: mask=%h match=%b want 80 1", mask1, match1);
        end
    endtask

    task automatic test_start_ignored();
        int dones, first_done;
        tab0 = 8'h3C; exp0 = 8'h3C;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        dones = 0; first_done = -1;
        for (int k = 1; k <= 20; k++) begin
            start0 = (k == 2 || k == 5);
            @(posedge clk); #1;
            start0 = 1'b0;
            if (done0 === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = k;
            end
        end
        total++;
        if (dones != 1 || first_done != 8) begin
            bad++; $display("FAIL ignore_start: dones=%0d at=%0d want 1 at 8", dones, first_done);
        end
        total++;
        if (mask0 !== 8'h3C || match0 !== 1'b1 || busy0 !== 1'b0) begin
            bad++; $display("FAIL ignore_start result: mask=%h match=%b busy=%b want 3c 1 0", mask0, match0, busy0);
        end
    endtask

    task automatic test_abort();
        int dones;
        tab0 = 8'h5A; exp0 = 8'h5A;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (4) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        total++;
        if ({abc0, busy0, done0, mask0, match0} !== 13'd0) begin
            bad++; $display("FAIL abort: got %b want 0", {abc0, busy0, done0, mask0, match0});
        end
        dones = 0;
        repeat (3) begin @(posedge clk); #1; if (done0 === 1'b1) dones++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (done0 === 1'b1) dones++; end
        total++;
        if (dones != 0 || busy0 !== 1'b0) begin
            bad++; $display("FAIL abort_quiet: dones=%0d busy=%b want 0 0", dones, busy0);
        end
        run_sweep0(8'hA7, 8'hA7, "after_abort");
    endtask

    task automatic test_back_to_back();
        int last, n, k;
        tab0 = 8'h96; exp0 = 8'h96;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1;
        last = 0; n = 0; k = 0;
        while (n < 3 && k < 60) begin
            @(posedge clk); #1; k++;
            if (done0 === 1'b1) begin
                total++;
                if (k - last != ((n == 0) ? 8 : 9)) begin
                    bad++; $display("FAIL b2b gap%0d: got %0d want %0d", n, k - last, (n == 0) ? 8 : 9);
                end
                total++;
                if (mask0 !== 8'h96 || match0 !== 1'b1) begin
                    bad++; $display("FAIL b2b mask%0d: got %h/%b want 96/1", n, mask0, match0);
                end
                last = k; n++;
            end
        end
        total++;
        if (n != 3) begin bad++; $display("FAIL b2b count: got %0d want 3", n); end
        start0 = 1'b0;
        k = 0;
        while (busy0 === 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        total++;
        if (busy0 !== 1'b0) begin bad++; $display("FAIL b2b drain: busy=%b want 0", busy0); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [7:0] t, e;
        for (int i = 0; i < 10; i++) begin
            t = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? t : 8'($urandom);
            run_sweep0(t, e, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_udp();
        test_mismatch();
        test_settle3();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
